// File: rtl/pdn_rail_sequencer.sv
// Power-up/power-down sequencer for NUM_RAILS supply domains with PG timeout and brown-out shutdown.
// Define PDN_PG_DEBOUNCE_EN to filter each rail_pg bit over DEBOUNCE_CYC consecutive equal samples.
module pdn_rail_sequencer #(
    parameter int NUM_RAILS    = 8,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int SETTLE_CYC   = 16,
    parameter int DEBOUNCE_CYC = 4,
    localparam int IDX_W       = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 on_req,
    input  logic                 clr_fault,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 pwr_good,
    output logic                 busy,
    output logic                 fault,
    output logic [IDX_W-1:0]     fault_idx
);

    localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [2:0] OFF       = 3'd0;
    localparam logic [2:0] UP_EN     = 3'd1;
    localparam logic [2:0] UP_SETTLE = 3'd2;
    localparam logic [2:0] ON        = 3'd3;
    localparam logic [2:0] DN_DIS    = 3'd4;
    localparam logic [2:0] DN_SETTLE = 3'd5;
    localparam logic [2:0] FAULT     = 3'd6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    if (NUM_RAILS < 1 || NUM_RAILS > 64 || TIMEOUT_CYC < 1 || SETTLE_CYC < 1 || DEBOUNCE_CYC < 1)
    begin : g_bad_cfg
        $error("pdn_rail_sequencer: illegal parameter combination");
    end

    logic [2:0]           state, state_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [TMR_W-1:0]     timer, timer_d, timer_inc;
    logic [NUM_RAILS-1:0] rail_en_d;
    logic [IDX_W-1:0]     fault_idx_d;
    logic [NUM_RAILS-1:0] pg;
    logic [NUM_RAILS-1:0] chk_mask;
    logic [NUM_RAILS-1:0] bad;
    logic [IDX_W-1:0]     bad_idx;

`ifdef PDN_PG_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DB_W-1:0]      db_cnt [NUM_RAILS];
    logic [NUM_RAILS-1:0] pg_filt;

    // A bit flips only on the DEBOUNCE_CYC-th consecutive sample that disagrees with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pg_filt <= '0;
            for (int i = 0; i < NUM_RAILS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RAILS; i++) begin
                if (rail_pg[i] == pg_filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    pg_filt[i] <= rail_pg[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign pg = pg_filt;
`else
    assign pg = rail_pg;
`endif

    // Brown-out watch: every rail in ON, only rails already sequenced below idx otherwise.
    always_comb begin
        chk_mask = '0;
        bad_idx  = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            if (state == ON)
                chk_mask[i] = 1'b1;
            else if (state inside {UP_EN, UP_SETTLE, DN_DIS, DN_SETTLE})
                chk_mask[i] = (i < int'(idx));
        end
        bad = chk_mask & ~pg;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (bad[i]) bad_idx = IDX_W'(i);
        end
    end

    assign timer_inc = (timer == TMR_W'(TMR_MAX)) ? timer : timer + TMR_W'(1);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        timer_d     = timer;
        rail_en_d   = rail_en;
        fault_idx_d = fault_idx;

        case (state)
            OFF: begin
                if (on_req) begin
                    state_d          = UP_EN;
                    idx_d            = '0;
                    timer_d          = '0;
                    rail_en_d[idx_d] = 1'b1;
                end
            end
            UP_EN: begin
                if (|bad) begin
                    state_d     = FAULT;
                    fault_idx_d = bad_idx;
                end else if (!pg[idx] && timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = FAULT;
                    fault_idx_d = idx;
                end else if (!on_req) begin
                    state_d        = DN_DIS;
                    timer_d        = '0;
                    rail_en_d[idx] = 1'b0;
                end else if (pg[idx]) begin
                    state_d = UP_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            UP_SETTLE: begin
                if (|bad) begin
                    state_d     = FAULT;
                    fault_idx_d = bad_idx;
                end else if (!on_req) begin
                    state_d        = DN_DIS;
                    timer_d        = '0;
                    rail_en_d[idx] = 1'b0;
                end else if (timer == TMR_W'(SETTLE_CYC - 1)) begin
                    timer_d = '0;
                    if (idx == LAST_IDX) begin
                        state_d = ON;
                    end else begin
                        state_d          = UP_EN;
                        idx_d            = idx + IDX_W'(1);
                        rail_en_d[idx_d] = 1'b1;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            ON: begin
                if (|bad) begin
                    state_d     = FAULT;
                    fault_idx_d = bad_idx;
                end else if (!on_req) begin
                    state_d             = DN_DIS;
                    idx_d               = LAST_IDX;
                    timer_d             = '0;
                    rail_en_d[LAST_IDX] = 1'b0;
                end
            end
            DN_DIS: begin
                if (|bad) begin
                    state_d     = FAULT;
                    fault_idx_d = bad_idx;
                end else if (!pg[idx]) begin
                    state_d = DN_SETTLE;
                    timer_d = '0;
                end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = FAULT;
                    fault_idx_d = idx;
                end else begin
                    timer_d = timer_inc;
                end
            end
            DN_SETTLE: begin
                if (|bad) begin
                    state_d     = FAULT;
                    fault_idx_d = bad_idx;
                end else if (timer == TMR_W'(SETTLE_CYC - 1)) begin
                    timer_d = '0;
                    if (idx == '0) begin
                        state_d = OFF;
                    end else begin
                        state_d          = DN_DIS;
                        idx_d            = idx - IDX_W'(1);
                        rail_en_d[idx_d] = 1'b0;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            FAULT: begin
                if (clr_fault && !on_req) begin
                    state_d     = OFF;
                    idx_d       = '0;
                    timer_d     = '0;
                    fault_idx_d = '0;
                end
            end
            default: begin
                state_d = FAULT;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase

        // Any entry into FAULT drops every rail in the same edge.
        if (state_d == FAULT) rail_en_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OFF;
            idx       <= '0;
            timer     <= '0;
            rail_en   <= '0;
            pwr_good  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            fault_idx <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            timer     <= timer_d;
            rail_en   <= rail_en_d;
            pwr_good  <= (state_d == ON);
            busy      <= (state_d inside {UP_EN, UP_SETTLE, DN_DIS, DN_SETTLE});
            fault     <= (state_d == FAULT);
            fault_idx <= fault_idx_d;
        end
    end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Directed bench for pdn_rail_sequencer: 4 rails, timeout 8, settle 2, with a simple rail/PG model.
module tb_pdn_rail_sequencer;

    localparam int NR  = 4;
    localparam int TO  = 8;
    localparam int ST  = 2;
    localparam int DB  = 4;
    localparam int UPD = 3;   // PG rises so it is sampled on the 3rd edge after enable
    localparam int DND = 1;   // PG falls so it is sampled on the 1st edge after disable
`ifdef PDN_PG_DEBOUNCE_EN
    localparam int PGL = DB;
`else
    localparam int PGL = 0;
`endif
    localparam int UPS = UPD + PGL + ST;
    localparam int DNS = DND + PGL + ST;

    logic          clk = 1'b0;
    logic          rst;
    logic          on_req;
    logic          clr_fault;
    logic [NR-1:0] rail_pg;
    logic [NR-1:0] rail_en;
    logic          pwr_good;
    logic          busy;
    logic          fault;
    logic [1:0]    fault_idx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NR-1:0] stuck;
    logic [NR-1:0] force_lo;
    logic [NR-1:0] model_pg;
    logic [NR-1:0] prev_en;
    int            cnt [NR];

    pdn_rail_sequencer #(
        .NUM_RAILS    (NR),
        .TIMEOUT_CYC  (TO),
        .SETTLE_CYC   (ST),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .on_req    (on_req),
        .clr_fault (clr_fault),
        .rail_pg   (rail_pg),
        .rail_en   (rail_en),
        .pwr_good  (pwr_good),
        .busy      (busy),
        .fault     (fault),
        .fault_idx (fault_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_pg();
        rail_pg = model_pg & ~force_lo;
    endtask

    // Advance n edges, then update the rail model from the freshly registered rail_en.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (rail_en[i] != prev_en[i]) cnt[i] = 0;
                cnt[i]++;
                if (rail_en[i] && cnt[i] >= UPD && !stuck[i]) model_pg[i] = 1'b1;
                if (!rail_en[i] && cnt[i] >= DND) model_pg[i] = 1'b0;
            end
            prev_en = rail_en;
            apply_pg();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        on_req    = 1'b0;
        clr_fault = 1'b0;
        rail_pg   = '0;
        stuck     = '0;
        force_lo  = '0;
        model_pg  = '0;
        prev_en   = '0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        #2 rst = 1'b1;
        tick(2);
        check("rst_rail_en", 32'(rail_en), 32'h0);
        check("rst_flags", 32'({pwr_good, busy, fault}), 32'h0);
        check("rst_fault_idx", 32'(fault_idx), 32'h0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", 32'(busy), 32'h0);

        // Nominal power-up
        on_req = 1'b1;
        tick();
        check("up_r0", 32'(rail_en), 32'h1);
        check("up_busy", 32'(busy), 32'h1);
        tick(UPS - 1);
        check("up_r0_hold", 32'(rail_en), 32'h1);
        tick();
        check("up_r1", 32'(rail_en), 32'h3);
        tick(UPS);
        check("up_r2", 32'(rail_en), 32'h7);
        tick(UPS);
        check("up_r3", 32'(rail_en), 32'hF);
        tick(UPS - 1);
        check("up_pg_early", 32'(pwr_good), 32'h0);
        tick();
        check("up_pwr_good", 32'(pwr_good), 32'h1);
        check("up_busy_done", 32'(busy), 32'h0);

        // Nominal power-down
        on_req = 1'b0;
        tick();
        check("dn_r3", 32'(rail_en), 32'h7);
        check("dn_pwr_good", 32'(pwr_good), 32'h0);
        check("dn_busy", 32'(busy), 32'h1);
        tick(DNS);
        check("dn_r2", 32'(rail_en), 32'h3);
        tick(DNS);
        check("dn_r1", 32'(rail_en), 32'h1);
        tick(DNS);
        check("dn_r0", 32'(rail_en), 32'h0);
        tick(DNS - 1);
        check("dn_busy_tail", 32'(busy), 32'h1);
        tick();
        check("dn_off", 32'({pwr_good, busy, fault}), 32'h0);
        tick(8);

        // Power-up timeout on rail 2
        stuck  = 4'b0100;
        on_req = 1'b1;
        tick();
        tick(2 * UPS);
        check("to_r2_en", 32'(rail_en), 32'h7);
        tick(TO - 1);
        check("to_not_yet", 32'(fault), 32'h0);
        tick();
        check("to_rail_en", 32'(rail_en), 32'h0);
        check("to_fault", 32'(fault), 32'h1);
        check("to_fault_idx", 32'(fault_idx), 32'h2);
        check("to_busy", 32'(busy), 32'h0);
        clr_fault = 1'b1;
        tick();
        check("to_clr_ignored", 32'(fault), 32'h1);
        on_req = 1'b0;
        tick();
        check("to_clr_fault", 32'(fault), 32'h0);
        clr_fault = 1'b0;
        stuck     = '0;
        tick(8);

        // Brown-out in ON
        on_req = 1'b1;
        tick(1 + 4 * UPS);
        check("bo_on", 32'(pwr_good), 32'h1);
`ifdef PDN_PG_DEBOUNCE_EN
        force_lo = 4'b0100;
        apply_pg();
        tick(3);
        force_lo = '0;
        apply_pg();
        tick(DB + 2);
        check("glitch_no_fault", 32'(fault), 32'h0);
        check("glitch_still_on", 32'(pwr_good), 32'h1);
`endif
        force_lo = 4'b0010;
        apply_pg();
        tick(PGL);
        check("bo_hold", 32'(rail_en), 32'hF);
        tick();
        check("bo_rail_en", 32'(rail_en), 32'h0);
        check("bo_fault", 32'(fault), 32'h1);
        check("bo_fault_idx", 32'(fault_idx), 32'h1);
        check("bo_pwr_good", 32'(pwr_good), 32'h0);
        on_req    = 1'b0;
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        force_lo  = '0;
        apply_pg();
        check("bo_cleared", 32'(fault), 32'h0);
        tick(8);

        // Abort during UP_SETTLE of rail 1
        on_req = 1'b1;
        tick();
        tick(UPS);
        check("ab_r1_en", 32'(rail_en), 32'h3);
        tick(UPD + PGL);
        on_req = 1'b0;
        tick();
        check("ab_r1_off", 32'(rail_en), 32'h1);
        check("ab_busy", 32'(busy), 32'h1);
        tick();
        on_req = 1'b1;
        tick();
        on_req = 1'b0;
        check("ab_no_reenable", 32'(rail_en), 32'h1);
        tick(DNS - 2);
        check("ab_r0_off", 32'(rail_en), 32'h0);
        tick(DNS - 1);
        check("ab_busy_tail", 32'(busy), 32'h1);
        tick();
        check("ab_off", 32'({pwr_good, busy, fault}), 32'h0);
        tick(8);

        // Async reset in the middle of UP_EN
        on_req = 1'b1;
        tick();
        check("ar_r0_en", 32'(rail_en), 32'h1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("ar_rail_en", 32'(rail_en), 32'h0);
        check("ar_flags", 32'({pwr_good, busy, fault}), 32'h0);
        on_req = 1'b0;
        tick();
        rst = 1'b0;
        tick(2);
        check("ar_after", 32'({rail_en, busy}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdn_rail_sequencer.md
Name: pdn_rail_sequencer

Overview:
- Parametrised power-up/power-down sequencer for NUM_RAILS independently switched supply domains on the power distribution network.
- Enables rails in ascending index order and waits for each rail's power-good before moving on. Disables rails in descending order.
- Detects power-good timeouts and brown-outs, then performs an emergency shutdown.
- Sits between the top-level power controller (on request) and the per-domain rail switches / PG monitors.

Parameters:
- NUM_RAILS, 8, number of sequenced rails (1..64).
- TIMEOUT_CYC, 1024, max cycles to wait for PG to assert (up) or deassert (down) per rail.
- SETTLE_CYC, 16, dwell cycles after each rail transition before the next rail is touched (>=1).
- DEBOUNCE_CYC, 4, PG stable-cycle count; used only when PDN_PG_DEBOUNCE_EN is defined.
- Derived (localparam, not overridable): IDX_W = max(1, clog2(NUM_RAILS)); TMR_W = clog2(max(TIMEOUT_CYC, SETTLE_CYC) + 1).

Ports:
- clk  input  1  sequencer clock.
- rst  input  1  asynchronous, active-high reset.
- on_req  input  1  level request: 1 = rails on, 0 = rails off.
- clr_fault  input  1  single-cycle fault acknowledge.
- rail_pg  input  NUM_RAILS  per-rail power-good, already synchronised to clk upstream.
- rail_en  output  NUM_RAILS  per-rail switch enable, registered.
- pwr_good  output  1  all rails up and settled (state ON).
- busy  output  1  sequence in progress (UP_EN, UP_SETTLE, DN_DIS, DN_SETTLE).
- fault  output  1  sticky fault flag.
- fault_idx  output  IDX_W  index of the rail that caused the fault.

Behaviour:
- Reset (async assert, sync release): state=OFF, idx=0, timer=0, all outputs 0. Reset mid-sequence drops every rail_en in the same instant.
- States: OFF, UP_EN, UP_SETTLE, ON, DN_DIS, DN_SETTLE, FAULT. All outputs are registered and change on the edge that enters the state.
- OFF:
  - on_req=1 -> UP_EN with idx=0.
- UP_EN:
  - rail_en[idx] set on entry; timer counts from 0.
  - rail_pg[idx]=1 -> UP_SETTLE, timer cleared.
  - timer==TIMEOUT_CYC-1 and no PG -> FAULT, fault_idx=idx.
- UP_SETTLE:
  - Dwell SETTLE_CYC cycles.
  - Then idx==NUM_RAILS-1 -> ON; else idx+1 -> UP_EN.
- Abort during power-up: on_req=0 in UP_EN or UP_SETTLE -> DN_DIS at the current idx. The rail just enabled is included.
- ON:
  - pwr_good=1, busy=0.
  - Any rail_pg bit = 0 -> FAULT, fault_idx = lowest-index failing rail.
  - Otherwise on_req=0 -> DN_DIS with idx=NUM_RAILS-1.
- DN_DIS:
  - rail_en[idx] cleared on entry.
  - rail_pg[idx]=0 -> DN_SETTLE.
  - timeout -> FAULT, fault_idx=idx.
- DN_SETTLE:
  - Dwell SETTLE_CYC cycles.
  - Then idx==0 -> OFF; else idx-1 -> DN_DIS.
- Power-down runs to completion even if on_req returns to 1. Re-power-up starts from OFF on the following cycle.
- Spurious PG drop during a sequence:
  - In UP_SETTLE or UP_EN, a rail below idx losing PG -> FAULT for that rail.
  - In DN states, PG is checked only for rails below idx.
- FAULT:
  - All rail_en cleared simultaneously; fault=1, busy=0, pwr_good=0.
  - Exit to OFF only when clr_fault=1 and on_req=0 in the same cycle. clr_fault with on_req=1 is ignored.
- Priority: rst > fault detection > on_req change > timer expiry (settle).
- The timer saturates and never wraps. NUM_RAILS=1 is legal: idx stays 0.

Optional Feature:
- PDN_PG_DEBOUNCE_EN defined:
  - Each rail_pg bit is filtered by a per-rail counter; the filtered value changes only after DEBOUNCE_CYC consecutive equal samples.
  - All PG checks (transitions and fault detection) use the filtered value.
  - Timeout still counts raw cycles.
- Undefined: rail_pg is used directly, with no added latency or filter logic.

Test Plan:
- Setup for all scenarios: NUM_RAILS=4, TIMEOUT_CYC=8, SETTLE_CYC=2.
- Nominal up: on_req=1, each PG asserts 3 cycles after its enable -> rail_en steps 0001, 0011, 0111, 1111, 5 cycles apart. pwr_good=1 two cycles after rail 3 PG; busy=0.
- Nominal down from ON: on_req=0, each PG drops 1 cycle after disable -> rail_en 0111, 0011, 0001, 0000 in reverse order. State OFF; pwr_good=0 from the first edge.
- Up timeout: rail 2 PG never asserts -> 8 cycles after rail_en[2] rises, rail_en=0000, fault=1, fault_idx=2. clr_fault with on_req=1 is ignored; with on_req=0 it returns to OFF and fault=0.
- Brown-out in ON: force rail_pg=1101 -> next edge rail_en=0000, fault_idx=1.
- Abort: on_req=0 while in UP_SETTLE of rail 1 -> rail 1 disabled first, then rail 0; OFF reached. on_req=1 pulsed during the down sequence does not interrupt it.
- Async reset asserted mid-UP_EN -> all outputs 0 immediately, without waiting for a clock edge. With PDN_PG_DEBOUNCE_EN and DEBOUNCE_CYC=4, a 3-cycle PG glitch in ON causes no fault.
